// File: rtl/reg_file_pkg.sv
// Shared constants and state encoding for the write-back register file
// and its post-reset clear sweep.
package reg_file_pkg;

    localparam int NUM_REGS = 32;
    localparam int ZERO_REG = 0;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_IDLE  = 1'b1
    } rf_state_t;

endpackage

// File: rtl/reg_file_clear_fsm.sv
// Post-reset sweep controller: walks every storage index once, requesting
// a zero write at each, then parks in IDLE until the next reset.
module reg_file_clear_fsm
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    output logic              clear_we,
    output logic [ADDR_W-1:0] clear_idx,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    rf_state_t         r_state;
    rf_state_t         w_state_nxt;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] w_idx_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RF_CLEAR;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        clear_we    = 1'b0;
        busy        = 1'b0;
        case (r_state)
            RF_CLEAR: begin
                busy      = 1'b1;
                clear_we  = 1'b1;
                w_idx_nxt = r_idx + ADDR_W'(1);
                // The last entry is zeroed on the same edge that leaves CLEAR.
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = RF_IDLE;
                end
            end
            RF_IDLE: begin
                w_state_nxt = RF_IDLE;
            end
        endcase
    end

    assign clear_idx = r_idx;

endmodule

// File: rtl/reg_file_wb.sv
// Write-back register file: 2**ADDR_W x DATA_W, one handshaked write port, two
// async read ports, $0 hardwired to zero. Define REG_FILE_BYPASS_EN for write-through reads.
module reg_file_wb
    import reg_file_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    output logic              WrReady,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic              Busy
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_clear_we;
    logic [ADDR_W-1:0] w_clear_idx;
    logic              w_busy;
    logic              w_wr_accept;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_data;

    reg_file_clear_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clk       (CLK),
        .rst       (RST),
        .clear_we  (w_clear_we),
        .clear_idx (w_clear_idx),
        .busy      (w_busy)
    );

    assign WrReady = !w_busy;
    assign Busy    = w_busy;

    // Reset overrides a pending write even when the FSM already reports ready.
    assign w_wr_accept = RegWrite && !w_busy && !RST;

    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_addr = w_clear_idx;
        w_mem_data = '0;
        if (w_clear_we) begin
            w_mem_we = 1'b1;
        end else if (w_wr_accept && (WriteReg != ZERO_IDX)) begin
            w_mem_we   = 1'b1;
            w_mem_addr = WriteReg;
            w_mem_data = WriteData;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    always_comb begin
        ReadData1 = '0;
        if (!w_busy && (ReadReg1 != ZERO_IDX)) begin
            ReadData1 = r_mem[ReadReg1];
`ifdef REG_FILE_BYPASS_EN
            if (RegWrite && (WriteReg == ReadReg1)) begin
                ReadData1 = WriteData;
            end
`endif
        end
    end

    always_comb begin
        ReadData2 = '0;
        if (!w_busy && (ReadReg2 != ZERO_IDX)) begin
            ReadData2 = r_mem[ReadReg2];
`ifdef REG_FILE_BYPASS_EN
            if (RegWrite && (WriteReg == ReadReg2)) begin
                ReadData2 = WriteData;
            end
`endif
        end
    end

endmodule
